// File: rtl/md_cart_bridge.sv
// md_cart_bridge: turns cartridge-bus strobes into req/ack memory cycles with a one-word read cache,
// a TIME-window SRAM enable and an access timeout.
module md_cart_bridge #(
  parameter logic [22:0] ROM_MASK   = 23'h7FFFFF,
  parameter logic [22:0] SRAM_BASE  = 23'h100000,
  parameter int          SRAM_WORDS = 32768,
  parameter int          TIMEOUT    = 255
) (
  input  logic        MCLK2,
  input  logic        ext_reset,
  input  logic [22:0] cart_address,
  input  logic        cart_cs,
  input  logic        cart_oe,
  input  logic        cart_uwr,
  input  logic        cart_lwr,
  input  logic        cart_time,
  input  logic [15:0] cart_data_wr,
  output logic [15:0] cart_data,
  output logic        cart_data_en,
  output logic [22:0] mem_addr,
  output logic        mem_sram,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        sram_en,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, HOLD, WAIT_REL} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [23:0] SRAM_END = {1'b0, SRAM_BASE} + 24'(SRAM_WORDS);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [22:0] mem_addr_d, cache_addr, cache_addr_d, map_addr;
  logic [15:0] cart_data_d, mem_wdata_d, cache_data, cache_data_d;
  logic [1:0] mem_be_d;
  logic cart_data_en_d, mem_sram_d, mem_rd_d, mem_wr_d, sram_en_d, err_d;
  logic cache_valid, cache_valid_d, cache_sram, cache_sram_d;
  logic rd, wr, tw, hit, cache_hit, timeout;
  assign rd = cart_cs & cart_oe;
  assign wr = cart_cs & (cart_uwr | cart_lwr);
  assign tw = cart_time & cart_lwr;
  assign hit = sram_en && cart_address >= SRAM_BASE && {1'b0, cart_address} < SRAM_END;
  assign map_addr = hit ? cart_address - SRAM_BASE : cart_address & ROM_MASK;
  assign cache_hit = cache_valid && cache_addr == map_addr && cache_sram == hit;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state;
    cnt_d = '0;
    cart_data_d = cart_data;
    cart_data_en_d = cart_data_en;
    mem_addr_d = mem_addr;
    mem_sram_d = mem_sram;
    mem_rd_d = mem_rd;
    mem_wr_d = mem_wr;
    mem_be_d = mem_be;
    mem_wdata_d = mem_wdata;
    sram_en_d = sram_en;
    err_d = err;
    cache_valid_d = cache_valid;
    cache_addr_d = cache_addr;
    cache_sram_d = cache_sram;
    cache_data_d = cache_data;
    case (state)
      IDLE:
        if (tw) begin
          sram_en_d = cart_data_wr[0];
          state_d = WAIT_REL;
        end else if (wr) begin
          state_d = hit ? WR_REQ : WAIT_REL;
          if (hit) begin
            mem_wr_d = 1'b1;
            mem_be_d = {cart_uwr, cart_lwr};
            mem_addr_d = map_addr;
            mem_sram_d = 1'b1;
            mem_wdata_d = cart_data_wr;
            cache_valid_d = 1'b0;
          end
        end else if (rd) begin
          state_d = cache_hit ? HOLD : RD_REQ;
          if (cache_hit) begin
            cart_data_d = cache_data;
            cart_data_en_d = 1'b1;
          end else begin
            mem_rd_d = 1'b1;
            mem_addr_d = map_addr;
            mem_sram_d = hit;
          end
        end
      RD_REQ:
        if (mem_ack || timeout) begin
          mem_rd_d = 1'b0;
          cart_data_d = mem_ack ? mem_rdata : 16'hFFFF;
          cart_data_en_d = rd;
          err_d = err | ~mem_ack;
          state_d = rd ? HOLD : IDLE;
          if (mem_ack) begin
            cache_valid_d = 1'b1;
            cache_addr_d = mem_addr;
            cache_sram_d = mem_sram;
            cache_data_d = mem_rdata;
          end
        end else cnt_d = cnt + 1'b1;
      WR_REQ:
        if (mem_ack || timeout) begin
          mem_wr_d = 1'b0;
          err_d = err | ~mem_ack;
          state_d = WAIT_REL;
        end else cnt_d = cnt + 1'b1;
      HOLD:
        if (!rd) begin
          cart_data_en_d = 1'b0;
          state_d = IDLE;
        end
      WAIT_REL: state_d = (cart_cs | cart_uwr | cart_lwr | cart_time) ? WAIT_REL : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge MCLK2 or posedge ext_reset)
    if (ext_reset) begin
      state <= IDLE;
      cnt <= '0;
      cart_data <= '0;
      cart_data_en <= 1'b0;
      mem_addr <= '0;
      mem_sram <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      mem_be <= '0;
      mem_wdata <= '0;
      sram_en <= 1'b0;
      err <= 1'b0;
      cache_valid <= 1'b0;
      cache_addr <= '0;
      cache_sram <= 1'b0;
      cache_data <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      cart_data <= cart_data_d;
      cart_data_en <= cart_data_en_d;
      mem_addr <= mem_addr_d;
      mem_sram <= mem_sram_d;
      mem_rd <= mem_rd_d;
      mem_wr <= mem_wr_d;
      mem_be <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      sram_en <= sram_en_d;
      err <= err_d;
      cache_valid <= cache_valid_d;
      cache_addr <= cache_addr_d;
      cache_sram <= cache_sram_d;
      cache_data <= cache_data_d;
    end
endmodule

// File: tb/tb_md_cart_bridge.sv
// tb_md_cart_bridge: drives cartridge-bus transactions against a memory/cache model of the bridge.
module tb_md_cart_bridge;
  logic MCLK2 = 1'b0, ext_reset = 1'b1;
  logic [22:0] cart_address = '0;
  logic cart_cs = 0, cart_oe = 0, cart_uwr = 0, cart_lwr = 0, cart_time = 0;
  logic [15:0] cart_data_wr = '0, mem_rdata = '0;
  logic mem_ack = 0;
  logic [15:0] cart_data, mem_wdata;
  logic cart_data_en, mem_sram, mem_rd, mem_wr, sram_en, err;
  logic [22:0] mem_addr;
  logic [1:0] mem_be;
  int vectors = 0, errors = 0;
  bit m_sram_en = 0, m_cv = 0;
  logic [23:0] m_ck;
  logic [15:0] mem [logic [23:0]];
  md_cart_bridge dut (
    .MCLK2(MCLK2), .ext_reset(ext_reset), .cart_address(cart_address), .cart_cs(cart_cs),
    .cart_oe(cart_oe), .cart_uwr(cart_uwr), .cart_lwr(cart_lwr), .cart_time(cart_time),
    .cart_data_wr(cart_data_wr), .cart_data(cart_data), .cart_data_en(cart_data_en),
    .mem_addr(mem_addr), .mem_sram(mem_sram), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sram_en(sram_en), .err(err)
  );
  always #5 MCLK2 = ~MCLK2;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // memory key: {sram region, word address} as the bridge should present it
  function automatic logic [23:0] map_of(input logic [22:0] a);
    if (m_sram_en && a >= 23'h100000 && a < 23'h100000 + 32768) return {1'b1, a - 23'h100000};
    return {1'b0, a};
  endfunction
  task automatic get_mem(input logic [23:0] k, output logic [15:0] v);
    if (!mem.exists(k)) mem[k] = 16'($urandom);
    v = mem[k];
  endtask
  task automatic release_bus();
    cart_cs = 0; cart_oe = 0; cart_uwr = 0; cart_lwr = 0; cart_time = 0;
    @(negedge MCLK2);
  endtask
  task automatic do_read(input logic [22:0] a, input int d);
    logic [23:0] k;
    logic [15:0] v;
    bit hit;
    k = map_of(a);
    get_mem(k, v);
    hit = m_cv && m_ck == k;
    cart_address = a; cart_cs = 1; cart_oe = 1;
    @(negedge MCLK2);
    if (hit) begin
      vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL hit_no_rd @%h: got %b expected 0", a, mem_rd); end
      vectors++; if (cart_data_en !== 1'b1 || cart_data !== v) begin errors++; $display("FAIL hit_data @%h: got en=%b %h expected en=1 %h", a, cart_data_en, cart_data, v); end
    end else begin
      vectors++; if (mem_rd !== 1'b1 || mem_addr !== k[22:0] || mem_sram !== k[23] || cart_data_en !== 1'b0) begin
        errors++; $display("FAIL miss_req @%h: got rd=%b addr=%h sram=%b en=%b expected rd=1 addr=%h sram=%b en=0", a, mem_rd, mem_addr, mem_sram, cart_data_en, k[22:0], k[23]);
      end
      repeat (d - 1) @(negedge MCLK2);
      vectors++; if (mem_rd !== 1'b1 || cart_data_en !== 1'b0) begin errors++; $display("FAIL miss_hold @%h: got rd=%b en=%b expected rd=1 en=0", a, mem_rd, cart_data_en); end
      mem_ack = 1; mem_rdata = v;
      @(negedge MCLK2);
      mem_ack = 0; mem_rdata = 16'($urandom);
      vectors++; if (mem_rd !== 1'b0 || cart_data_en !== 1'b1 || cart_data !== v) begin
        errors++; $display("FAIL miss_data @%h: got rd=%b en=%b %h expected rd=0 en=1 %h", a, mem_rd, cart_data_en, cart_data, v);
      end
      m_cv = 1; m_ck = k;
    end
    @(negedge MCLK2);
    vectors++; if (cart_data_en !== 1'b1 || cart_data !== v) begin errors++; $display("FAIL rd_held @%h: got en=%b %h expected en=1 %h", a, cart_data_en, cart_data, v); end
    cart_oe = 0; cart_cs = 0;
    @(negedge MCLK2);
    vectors++; if (cart_data_en !== 1'b0) begin errors++; $display("FAIL rd_drop @%h: got en=%b expected 0", a, cart_data_en); end
  endtask
  task automatic do_write(input logic [22:0] a, input logic [15:0] data, input logic u, input logic l, input int d);
    logic [23:0] k;
    logic [15:0] v;
    k = map_of(a);
    cart_address = a; cart_data_wr = data; cart_cs = 1; cart_uwr = u; cart_lwr = l;
    @(negedge MCLK2);
    if (k[23]) begin
      vectors++; if (mem_wr !== 1'b1 || mem_sram !== 1'b1 || mem_addr !== k[22:0] || mem_be !== {u, l} || mem_wdata !== data) begin
        errors++; $display("FAIL wr_req @%h: got wr=%b sram=%b addr=%h be=%b d=%h expected wr=1 sram=1 addr=%h be=%b d=%h", a, mem_wr, mem_sram, mem_addr, mem_be, mem_wdata, k[22:0], {u, l}, data);
      end
      repeat (d - 1) @(negedge MCLK2);
      mem_ack = 1;
      @(negedge MCLK2);
      mem_ack = 0;
      vectors++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL wr_done @%h: got wr=%b expected 0", a, mem_wr); end
      get_mem(k, v);
      if (u) v[15:8] = data[15:8];
      if (l) v[7:0] = data[7:0];
      mem[k] = v;
      m_cv = 0;
    end else begin
      cart_oe = 1;
      @(negedge MCLK2);
      vectors++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL rom_wr_drop @%h: got wr=%b rd=%b expected 0 0", a, mem_wr, mem_rd); end
    end
    release_bus();
  endtask
  task automatic do_tw(input bit b);
    cart_time = 1; cart_lwr = 1; cart_data_wr = {15'($urandom), b};
    @(negedge MCLK2);
    vectors++; if (sram_en !== b || mem_wr !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL tw: got sram_en=%b wr=%b rd=%b expected %b 0 0", sram_en, mem_wr, mem_rd, b); end
    m_sram_en = b;
    release_bus();
  endtask
  task automatic test_reset();
    repeat (2) @(negedge MCLK2);
    vectors++; if ({cart_data, cart_data_en, mem_addr, mem_sram, mem_rd, mem_wr, mem_be, mem_wdata, sram_en, err} !== '0) begin
      errors++; $display("FAIL reset_state: got data=%h en=%b addr=%h rd=%b wr=%b sram_en=%b err=%b expected all 0", cart_data, cart_data_en, mem_addr, mem_rd, mem_wr, sram_en, err);
    end
    ext_reset = 0;
    @(negedge MCLK2);
  endtask
  task automatic test_read_miss();
    mem[24'h000100] = 16'h4E71;
    do_read(23'h000100, 3);
  endtask
  task automatic test_cache_hit();
    do_read(23'h000100, 1);
  endtask
  task automatic test_sram();
    do_tw(1);
    do_write(23'h100004, 16'hBEEF, 1, 0, 2);
    do_read(23'h000100, 2);
    do_read(23'h100004, 1);
    do_read(23'h100004, 1);
  endtask
  task automatic test_rom_write();
    do_write(23'h000010, 16'h1234, 1, 1, 1);
  endtask
  task automatic test_early_release();
    logic [23:0] k;
    logic [15:0] v;
    k = map_of(23'h000300);
    get_mem(k, v);
    cart_address = 23'h000300; cart_cs = 1; cart_oe = 1;
    @(negedge MCLK2);
    vectors++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL early_req: got rd=%b expected 1", mem_rd); end
    cart_cs = 0; cart_oe = 0;
    @(negedge MCLK2);
    mem_ack = 1; mem_rdata = v;
    @(negedge MCLK2);
    mem_ack = 0;
    vectors++; if (mem_rd !== 1'b0 || cart_data_en !== 1'b0) begin errors++; $display("FAIL early_done: got rd=%b en=%b expected 0 0", mem_rd, cart_data_en); end
    m_cv = 1; m_ck = k;
    do_read(23'h000300, 1);
  endtask
  task automatic test_random();
    logic [22:0] pool [8];
    int op;
    logic [1:0] ul;
    pool = '{23'h000100, 23'h000200, 23'h000300, 23'h100004, 23'h100005, 23'h107FFF, 23'h108000, 23'h0FFFFF};
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0) do_tw($urandom_range(0, 3) != 0);
      else if (op <= 3) begin
        ul = 2'($urandom_range(1, 3));
        do_write(pool[$urandom_range(0, 7)], 16'($urandom), ul[1], ul[0], int'($urandom_range(1, 5)));
      end else do_read(pool[$urandom_range(0, 7)], int'($urandom_range(1, 5)));
    end
  endtask
  task automatic test_timeout();
    int n = 0;
    cart_address = 23'h000777; cart_cs = 1; cart_oe = 1;
    @(negedge MCLK2);
    while (mem_rd === 1'b1 && n < 300) begin n++; @(negedge MCLK2); end
    vectors++; if (n != 255) begin errors++; $display("FAIL timeout_len: got %0d cycles expected 255", n); end
    vectors++; if (cart_data_en !== 1'b1 || cart_data !== 16'hFFFF || err !== 1'b1) begin
      errors++; $display("FAIL timeout_result: got en=%b %h err=%b expected en=1 ffff err=1", cart_data_en, cart_data, err);
    end
    release_bus();
    do_read(23'h000200, 2);
    vectors++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask
  task automatic test_reset_mid_read();
    do_tw(1);
    cart_address = 23'h000400; cart_cs = 1; cart_oe = 1;
    @(negedge MCLK2);
    vectors++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rst_pre: got rd=%b expected 1", mem_rd); end
    #2 ext_reset = 1;
    #1;
    vectors++; if (mem_rd !== 1'b0 || cart_data_en !== 1'b0 || sram_en !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_async: got rd=%b en=%b sram_en=%b err=%b expected 0 0 0 0", mem_rd, cart_data_en, sram_en, err);
    end
    cart_cs = 0; cart_oe = 0;
    @(negedge MCLK2);
    ext_reset = 0; mem_ack = 1; mem_rdata = 16'h1234;
    @(negedge MCLK2);
    mem_ack = 0;
    vectors++; if (mem_rd !== 1'b0 || cart_data_en !== 1'b0 || cart_data !== 16'h0000) begin
      errors++; $display("FAIL late_ack: got rd=%b en=%b %h expected 0 0 0000", mem_rd, cart_data_en, cart_data);
    end
    m_sram_en = 0; m_cv = 0;
    do_read(23'h000100, 2);
  endtask
  initial begin
    test_reset();
    test_read_miss();
    test_cache_hit();
    test_sram();
    test_rom_write();
    test_early_release();
    test_random();
    test_timeout();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
